// File: rtl/hilo_div_pkg.sv
// Shared definitions for the HI/LO divider: default operand width and FSM state encoding.
package hilo_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/hilo_div_step.sv
// One restoring radix-2 division step: shift in the next dividend bit, subtract if it fits.
module div_step
    import hilo_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;

    // rem_i < divisor_i holds on entry, so the shifted value fits in WIDTH+1 bits
    // and the restored remainder always fits back into WIDTH bits.
    always_comb begin
        shifted = {rem_i, bit_i};
        qbit_o  = (shifted >= {1'b0, divisor_i});
        rem_o   = qbit_o ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/hilo_div.sv
// Iterative signed/unsigned divider feeding the HI/LO registers: one quotient bit per cycle.
module hilo_div
    import hilo_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             wdbz_q, wdbz_d;

    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q;

    logic             accept;
    logic             div_zero;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] quo_shift;

    assign accept   = start && !annul;
    assign div_zero = (divisor == '0);
    assign dvd_neg  = signed_div & dividend[WIDTH-1];
    assign dvs_neg  = signed_div & divisor[WIDTH-1];
    assign dvd_mag  = dvd_neg ? -dividend : dividend;
    assign dvs_mag  = dvs_neg ? -divisor : divisor;

    // quo_q starts as the dividend magnitude and is shifted left while quotient bits fill in from the right.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    assign quo_shift = {quo_q[WIDTH-2:0], step_qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = div_zero ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (annul) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_BUSY);
        done = (state_q == ST_DONE) && !annul;
    end

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        negq_d = negq_q;
        negr_d = negr_q;
        wdbz_d = wdbz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d  = '0;
                    dvs_d  = dvs_mag;
                    negq_d = dvd_neg ^ dvs_neg;
                    negr_d = dvd_neg;
                    wdbz_d = div_zero;
                    if (div_zero) begin
                        quo_d = '1;
                        rem_d = dividend;
                    end else begin
                        quo_d = dvd_mag;
                        rem_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // Sign correction is folded into the last step so results are final on entering DONE.
                if (cnt_q == LAST_STEP) begin
                    quo_d = negq_q ? -quo_shift : quo_shift;
                    rem_d = negr_q ? -step_rem : step_rem;
                end else begin
                    quo_d = quo_shift;
                    rem_d = step_rem;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            wdbz_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            wdbz_q <= wdbz_d;
        end
    end

    // Visible results only move on a real done, so an annulled DONE leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (done) begin
            quotient_q  <= quo_q;
            remainder_q <= rem_q;
            dbz_q       <= wdbz_q;
        end
    end

    assign quotient    = done ? quo_q  : quotient_q;
    assign remainder   = done ? rem_q  : remainder_q;
    assign div_by_zero = done ? wdbz_q : dbz_q;

endmodule

// File: doc/hilo_div.md
HILO_DIV -- requirements
Module: hilo_div

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL support any even WIDTH from 8 to 64.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request a divide; sampled only in IDLE.
REQ-005 signed_div  input  1  1 = DIV (two's-complement), 0 = DIVU; captured with start.
REQ-006 annul  input  1  abort the in-flight divide (pipeline flush or exception).
REQ-007 dividend  input  WIDTH  numerator; captured with start.
REQ-008 divisor  input  WIDTH  denominator; captured with start.
REQ-009 busy  output  1  high while a divide is in progress; drives the pipeline stall.
REQ-010 done  output  1  single-cycle pulse; results valid; drives the HI/LO write enable.
REQ-011 quotient  output  WIDTH  result for LO.
REQ-012 remainder  output  WIDTH  result for HI.
REQ-013 div_by_zero  output  1  qualified by done; the divisor was zero.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY, and DONE.
REQ-015 IDLE: start=1 and annul=0 SHALL capture the operands and mode and go to BUSY; a zero divisor SHALL go directly to DONE instead.
REQ-016 BUSY SHALL run one restoring radix-2 step per cycle for exactly WIDTH cycles, then go to DONE.
REQ-017 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-018 Latency: done SHALL be high WIDTH+1 cycles after the start cycle (33 for WIDTH=32), and 1 cycle after start for a zero divisor.
REQ-019 busy SHALL be 1 in BUSY and 0 in IDLE and DONE.
REQ-020 start SHALL be ignored in BUSY and DONE, with no queueing.
REQ-021 Signed mode SHALL divide operand magnitudes.
REQ-022 In signed mode the quotient SHALL be negated when the operand signs differ.
REQ-023 In signed mode the remainder SHALL take the sign of the dividend.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder, modulo 2^WIDTH.
REQ-025 Signed minimum/-1 SHALL yield quotient = minimum value and remainder = 0, with no flag.
REQ-026 A zero divisor SHALL yield quotient = all ones, remainder = captured dividend, and div_by_zero = 1.
REQ-027 annul in BUSY or DONE SHALL force IDLE on the next edge with no done pulse.
REQ-028 annul together with start in IDLE SHALL win, so no divide starts.
REQ-029 quotient, remainder, and div_by_zero SHALL hold their last completed values until the next done.
REQ-030 An annulled divide SHALL NOT alter quotient, remainder, or div_by_zero.

Reset
REQ-031 rst=1 SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, and div_by_zero=0, and clear the working registers.
REQ-032 rst SHALL override start and annul, and SHALL abort any in-flight divide without a done pulse.

Structure
REQ-033 The shared defines package SHALL hold the FSM state encoding and the default WIDTH; the op/funct codes remain where they already live.
REQ-034 One sub-module, div_step, SHALL exist: a combinational single-bit restoring step (partial remainder in; shifted remainder and quotient bit out), WIDTH-parametrised.
REQ-035 Sign handling, the FSM, and the WIDTH-iteration counter SHALL reside in hilo_div.

Verification
REQ-036 Unsigned 100/7 at WIDTH=32 -> quotient=14, remainder=2, div_by_zero=0; done exactly 33 cycles after start; busy high for cycles 1-32.
REQ-037 Signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; unsigned 0xFFFFFFFF/2 -> quotient=0x7FFFFFFF, remainder=1.
REQ-038 5/0 -> done 1 cycle after start, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-039 annul at cycle 10 of BUSY -> busy=0 next cycle, no done, outputs unchanged; a start 2 cycles later -> normal 33-cycle completion.
REQ-040 rst at cycle 5 of BUSY -> all outputs 0 next cycle, no done; a start during BUSY -> ignored, the first divide's result is unchanged.
REQ-041 Random WIDTH=8 regression against a reference model covering all 65536 operand pairs in both modes -> zero mismatches.
